// File: rtl/servo_pwm_driver.sv
// Servo PWM driver: maps the signed PID word to a clamped pulse width and emits a fixed-period frame.
// Optional build macro SLEW_LIMIT_EN limits the per-frame width change to SLEW_STEP cycles.
module servo_pwm_driver #(
  parameter int CNT_W        = 20,
  parameter int FRAME_CYCLES = 1000000,
  parameter int CENTER_PW    = 75000,
  parameter int MIN_PW       = 50000,
  parameter int MAX_PW       = 100000,
  parameter int GAIN_SHIFT   = 4,
  parameter int SLEW_STEP    = 500
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [15:0] pid_data,
  input  logic               pid_ready,
  output logic               pwm_out,
  output logic               frame_start,
  output logic [CNT_W-1:0]   pulse_width,
  output logic               sat
);

  // state   | meaning
  // ST_IDLE | disabled or just out of reset; counter parked at 0, output low
  // ST_RUN  | frames running; counter sweeps 0..FRAME_CYCLES-1
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam int TW = CNT_W + GAIN_SHIFT + 2;

  localparam logic [CNT_W-1:0]     LAST_C   = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CENTER_C = CNT_W'(CENTER_PW);
  localparam logic [CNT_W-1:0]     MIN_C    = CNT_W'(MIN_PW);
  localparam logic [CNT_W-1:0]     MAX_C    = CNT_W'(MAX_PW);
  localparam logic signed [TW-1:0] CENTER_S = TW'(CENTER_PW);
  localparam logic signed [TW-1:0] MIN_S    = TW'(MIN_PW);
  localparam logic signed [TW-1:0] MAX_S    = TW'(MAX_PW);

  if (FRAME_CYCLES >= (1 << CNT_W) || MIN_PW > CENTER_PW || CENTER_PW > MAX_PW ||
      MAX_PW >= FRAME_CYCLES || SLEW_STEP < 1) begin : g_bad_params
    $error("servo_pwm_driver: inconsistent parameters");
  end

  state_t state_q, state_d;

  logic [CNT_W-1:0]     counter;
  logic [CNT_W-1:0]     next_cnt;
  logic [CNT_W-1:0]     pending_pw;
  logic [CNT_W-1:0]     load_pw;
  logic [CNT_W-1:0]     clamp_pw;
  logic                 clamp_sat;
  logic signed [TW-1:0] pid_ext;
  logic signed [TW-1:0] target;
  logic                 wrap;
  logic                 start_frame;

  // Wide enough that the extreme pid word shifted and offset cannot overflow.
  assign pid_ext = {{(TW-16){pid_data[15]}}, pid_data};
  assign target  = CENTER_S + (pid_ext <<< GAIN_SHIFT);

  always_comb begin
    clamp_pw  = target[CNT_W-1:0];
    clamp_sat = 1'b0;
    if (target < MIN_S) begin
      clamp_pw  = MIN_C;
      clamp_sat = 1'b1;
    end else if (target > MAX_S) begin
      clamp_pw  = MAX_C;
      clamp_sat = 1'b1;
    end
  end

`ifdef SLEW_LIMIT_EN
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(SLEW_STEP);
  logic [CNT_W-1:0] diff;

  always_comb begin
    diff    = '0;
    load_pw = pending_pw;
    if (pending_pw > pulse_width) begin
      diff = pending_pw - pulse_width;
      if (diff > STEP_C) load_pw = pulse_width + STEP_C;
    end else begin
      diff = pulse_width - pending_pw;
      if (diff > STEP_C) load_pw = pulse_width - STEP_C;
    end
  end
`else
  assign load_pw = pending_pw;
`endif

  assign next_cnt    = counter + CNT_W'(1);
  assign wrap        = (state_q == ST_RUN) && (counter == LAST_C);
  assign start_frame = enable && ((state_q == ST_IDLE) || wrap);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable)  state_d = ST_RUN;
      ST_RUN:  if (!enable) state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  // pwm_out and frame_start are registered from the counter value the next cycle will hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter     <= '0;
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
      sat         <= 1'b0;
      pending_pw  <= CENTER_C;
      pulse_width <= CENTER_C;
    end else begin
      if (enable && pid_ready) begin
        pending_pw <= clamp_pw;
        sat        <= clamp_sat;
      end
      if (!enable) begin
        counter     <= '0;
        pwm_out     <= 1'b0;
        frame_start <= 1'b0;
      end else if (start_frame) begin
        counter     <= '0;
        frame_start <= 1'b1;
        pulse_width <= load_pw;
        pwm_out     <= (load_pw != '0);
      end else begin
        counter     <= next_cnt;
        frame_start <= 1'b0;
        pwm_out     <= (next_cnt < pulse_width);
      end
    end
  end

endmodule
